// File: rtl/color_pkg.sv
// Shared types and constants for the color vector encoder.
// Optional feature macro: COLOR_ENC_NEAREST_EN (nearest-palette quantization).
package color_pkg;

    // A palette code selects one of the four palette entries
    typedef logic [1:0] code_t;

    // Number of palette codes packed into one output vector
    localparam int SLOT_COUNT = 4;

    // Default palette, indexed by code 2'b00 .. 2'b11
    localparam logic [11:0] COLOR1_DEFAULT = 12'hF00;
    localparam logic [11:0] COLOR2_DEFAULT = 12'h0F0;
    localparam logic [11:0] COLOR3_DEFAULT = 12'h00F;
    localparam logic [11:0] COLOR4_DEFAULT = 12'hFF0;

    // Packer states: collecting colors, or presenting a finished vector
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/color_quantizer.sv
// Combinational 12-bit color to 2-bit palette code mapper.
// Default: exact match only, unmatched colors give code 2'b00 and flag unknown.
// With COLOR_ENC_NEAREST_EN defined: nearest entry by Manhattan distance,
// ties resolved toward the lowest code, unknown never raised.
module color_quantizer
    import color_pkg::*;
#(
    parameter logic [11:0] COLOR1 = COLOR1_DEFAULT,
    parameter logic [11:0] COLOR2 = COLOR2_DEFAULT,
    parameter logic [11:0] COLOR3 = COLOR3_DEFAULT,
    parameter logic [11:0] COLOR4 = COLOR4_DEFAULT
) (
    input  logic [11:0] i_color,
    output code_t       o_code,
    output logic        o_unknown
);

`ifdef COLOR_ENC_NEAREST_EN
    logic [5:0] w_dist [SLOT_COUNT];

    // Sum of per-channel absolute differences, at most 45
    function automatic logic [5:0] colorDistance(input logic [11:0] a, input logic [11:0] b);
        logic [3:0] dr;
        logic [3:0] dg;
        logic [3:0] db;
        dr = (a[11:8] > b[11:8]) ? (a[11:8] - b[11:8]) : (b[11:8] - a[11:8]);
        dg = (a[7:4]  > b[7:4])  ? (a[7:4]  - b[7:4])  : (b[7:4]  - a[7:4]);
        db = (a[3:0]  > b[3:0])  ? (a[3:0]  - b[3:0])  : (b[3:0]  - a[3:0]);
        return {2'b00, dr} + {2'b00, dg} + {2'b00, db};
    endfunction

    assign w_dist[0] = colorDistance(i_color, COLOR1);
    assign w_dist[1] = colorDistance(i_color, COLOR2);
    assign w_dist[2] = colorDistance(i_color, COLOR3);
    assign w_dist[3] = colorDistance(i_color, COLOR4);

    // Pick the closest entry; strict less-than keeps the lowest code on ties
    always_comb begin
        logic [5:0] best;
        best      = w_dist[0];
        o_code    = 2'b00;
        o_unknown = 1'b0;
        for (int i = 1; i < SLOT_COUNT; i++) begin
            if (w_dist[i] < best) begin
                best   = w_dist[i];
                o_code = code_t'(i);
            end
        end
    end
`else
    // Exact compare in code order so a duplicated palette entry maps to the lowest code
    always_comb begin
        o_code    = 2'b00;
        o_unknown = 1'b0;
        if (i_color == COLOR1) begin
            o_code = 2'b00;
        end else if (i_color == COLOR2) begin
            o_code = 2'b01;
        end else if (i_color == COLOR3) begin
            o_code = 2'b10;
        end else if (i_color == COLOR4) begin
            o_code = 2'b11;
        end else begin
            o_unknown = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/color_encoder.sv
// Packs a handshaked stream of 12-bit colors into 8-bit vectors of four
// 2-bit palette codes, with partial-vector flush and a sticky unknown flag.
// Optional feature macro: COLOR_ENC_NEAREST_EN (see color_quantizer).
module color_encoder
    import color_pkg::*;
#(
    parameter logic [11:0] COLOR1 = COLOR1_DEFAULT,
    parameter logic [11:0] COLOR2 = COLOR2_DEFAULT,
    parameter logic [11:0] COLOR3 = COLOR3_DEFAULT,
    parameter logic [11:0] COLOR4 = COLOR4_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] color_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  color_vec,
    output logic [2:0]  out_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_unknown,
    input  logic        err_clr
);

    state_t     r_state;
    logic [2:0] r_count;
    logic [7:0] r_slots;
    logic [2:0] r_outCount;
    logic       r_outValid;
    logic       r_err;

    code_t      w_code;
    logic       w_unknown;
    logic       w_accept;
    logic [2:0] w_slotBase;
    logic [2:0] w_nextCount;

    color_quantizer #(
        .COLOR1 (COLOR1),
        .COLOR2 (COLOR2),
        .COLOR3 (COLOR3),
        .COLOR4 (COLOR4)
    ) u_quantizer (
        .i_color   (color_in),
        .o_code    (w_code),
        .o_unknown (w_unknown)
    );

    assign in_ready    = ~rst & (r_state == FILL);
    assign w_accept    = in_valid & (r_state == FILL);
    assign w_slotBase  = {r_count[1:0], 1'b0};
    assign w_nextCount = r_count + 3'(w_accept);

    // Packer FSM: fill slots in order, then hold the vector until downstream takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_count    <= 3'd0;
            r_slots    <= 8'h00;
            r_outCount <= 3'd0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_slots[w_slotBase +: 2] <= w_code;
                    end
                    if ((w_nextCount == 3'(SLOT_COUNT)) || (flush && (w_nextCount != 3'd0))) begin
                        r_state    <= HOLD;
                        r_outCount <= w_nextCount;
                        r_outValid <= 1'b1;
                    end
                    r_count <= w_nextCount;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state    <= FILL;
                        r_count    <= 3'd0;
                        r_slots    <= 8'h00;
                        r_outCount <= 3'd0;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

`ifdef COLOR_ENC_NEAREST_EN
    assign r_err = 1'b0;
`else
    // Sticky unknown-color flag; a new unknown on the clearing edge wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && w_unknown) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end
`endif

    assign color_vec   = r_slots;
    assign out_count   = r_outCount;
    assign out_valid   = r_outValid;
    assign err_unknown = r_err;

endmodule

// File: tb/tb_color_encoder.sv
// Directed self-checking bench for color_encoder.
// Expected values are hand-computed from the palette F00/0F0/00F/FF0.
// Honors COLOR_ENC_NEAREST_EN for the unknown-color expectations.
module tb_color_encoder;

   logic        clk;
   logic        rst;
   logic [11:0] color_in;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [7:0]  color_vec;
   logic [2:0]  out_count;
   logic        out_valid;
   logic        out_ready;
   logic        err_unknown;
   logic        err_clr;

   int vectors;
   int miscompares;

   color_encoder dut (
      .clk         (clk),
      .rst         (rst),
      .color_in    (color_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .color_vec   (color_vec),
      .out_count   (out_count),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_unknown (err_unknown),
      .err_clr     (err_clr)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one color for exactly one edge
   task automatic sendColor(input logic [11:0] c);
      color_in = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      vectors++;
      if (in_ready !== 1'b0) begin
         $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); miscompares++;
      end
      vectors++;
      if ({color_vec, out_count, out_valid, err_unknown} !== 13'd0) begin
         $display("[TB] FAIL reset_outputs got vec=%h cnt=%0d ov=%b err=%b want all 0",
                  color_vec, out_count, out_valid, err_unknown); miscompares++;
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         $display("[TB] FAIL release_in_ready got %b want 1", in_ready); miscompares++;
      end
   endtask

   task automatic test_full_vector();
      logic [11:0] pal [4];
      pal[0] = 12'hF00; pal[1] = 12'h0F0; pal[2] = 12'h00F; pal[3] = 12'hFF0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         color_in = pal[i];
         in_valid = 1'b1;
         if (i == 3) begin
            vectors++;
            if (out_valid !== 1'b0) begin
               $display("[TB] FAIL early_out_valid got %b want 0", out_valid); miscompares++;
            end
         end
         tick();
      end
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || color_vec !== 8'hE4 || out_count !== 3'd4 || in_ready !== 1'b0) begin
         $display("[TB] FAIL full_vector got ov=%b vec=%h cnt=%0d ir=%b want 1 e4 4 0",
                  out_valid, color_vec, out_count, in_ready); miscompares++;
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || color_vec !== 8'h00) begin
         $display("[TB] FAIL full_release got ov=%b ir=%b vec=%h want 0 1 00",
                  out_valid, in_ready, color_vec); miscompares++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back_hold();
      out_ready = 1'b0;
      sendColor(12'hF00);
      sendColor(12'h0F0);
      sendColor(12'h00F);
      sendColor(12'hFF0);
      for (int i = 0; i < 10; i++) begin
         color_in = 12'h00F;
         in_valid = i[0];
         flush    = i[1];
         tick();
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || color_vec !== 8'hE4 || out_count !== 3'd4) begin
            $display("[TB] FAIL hold_cycle%0d got ov=%b ir=%b vec=%h cnt=%0d want 1 0 e4 4",
                     i, out_valid, in_ready, color_vec, out_count); miscompares++;
         end
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("[TB] FAIL hold_release got ov=%b ir=%b want 0 1", out_valid, in_ready); miscompares++;
      end
   endtask

   task automatic test_flush();
      sendColor(12'h00F);
      sendColor(12'hFF0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || color_vec !== 8'h0E || out_count !== 3'd2) begin
         $display("[TB] FAIL flush_partial got ov=%b vec=%h cnt=%0d want 1 0e 2",
                  out_valid, color_vec, out_count); miscompares++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("[TB] FAIL flush_empty got ov=%b ir=%b want 0 1", out_valid, in_ready); miscompares++;
      end
      sendColor(12'hF00);
      sendColor(12'h0F0);
      sendColor(12'h00F);
      color_in = 12'hFF0;
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || color_vec !== 8'hE4 || out_count !== 3'd4) begin
         $display("[TB] FAIL flush_with_fourth got ov=%b vec=%h cnt=%0d want 1 e4 4",
                  out_valid, color_vec, out_count); miscompares++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_unknown();
`ifdef COLOR_ENC_NEAREST_EN
      // 123 is distance 15 from 00F, the closest entry
      sendColor(12'h123);
      vectors++;
      if (err_unknown !== 1'b0) begin
         $display("[TB] FAIL nearest_err got %b want 0", err_unknown); miscompares++;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++;
      if (color_vec !== 8'h02 || out_count !== 3'd1 || out_valid !== 1'b1) begin
         $display("[TB] FAIL nearest_code got vec=%h cnt=%0d ov=%b want 02 1 1",
                  color_vec, out_count, out_valid); miscompares++;
      end
`else
      sendColor(12'h123);
      vectors++;
      if (err_unknown !== 1'b1) begin
         $display("[TB] FAIL unknown_set got %b want 1", err_unknown); miscompares++;
      end
      tick();
      tick();
      vectors++;
      if (err_unknown !== 1'b1) begin
         $display("[TB] FAIL unknown_sticky got %b want 1", err_unknown); miscompares++;
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vectors++;
      if (err_unknown !== 1'b0) begin
         $display("[TB] FAIL unknown_clear got %b want 0", err_unknown); miscompares++;
      end
      err_clr = 1'b1;
      sendColor(12'h456);
      vectors++;
      if (err_unknown !== 1'b1) begin
         $display("[TB] FAIL unknown_set_wins got %b want 1", err_unknown); miscompares++;
      end
      tick();
      err_clr = 1'b0;
      vectors++;
      if (err_unknown !== 1'b0) begin
         $display("[TB] FAIL unknown_clear2 got %b want 0", err_unknown); miscompares++;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++;
      if (color_vec !== 8'h00 || out_count !== 3'd2 || out_valid !== 1'b1) begin
         $display("[TB] FAIL unknown_code got vec=%h cnt=%0d ov=%b want 00 2 1",
                  color_vec, out_count, out_valid); miscompares++;
      end
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midfill();
      logic expErr;
`ifdef COLOR_ENC_NEAREST_EN
      expErr = 1'b0;
`else
      expErr = 1'b1;
`endif
      sendColor(12'hFF0);
      sendColor(12'h0F0);
      sendColor(12'h777);
      vectors++;
      if (color_vec === 8'h00 || err_unknown !== expErr) begin
         $display("[TB] FAIL midfill_state got vec=%h err=%b want nonzero %b",
                  color_vec, err_unknown, expErr); miscompares++;
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({color_vec, out_count, out_valid, err_unknown, in_ready} !== 14'd0) begin
         $display("[TB] FAIL async_reset got vec=%h cnt=%0d ov=%b err=%b ir=%b want all 0",
                  color_vec, out_count, out_valid, err_unknown, in_ready); miscompares++;
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) sendColor(12'h0F0);
      vectors++;
      if (out_valid !== 1'b1 || color_vec !== 8'h55 || out_count !== 3'd4) begin
         $display("[TB] FAIL after_reset got ov=%b vec=%h cnt=%0d want 1 55 4",
                  out_valid, color_vec, out_count); miscompares++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // Run every scenario in order, then report
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      color_in    = 12'h000;
      in_valid    = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b0;
      err_clr     = 1'b0;
      test_reset();
      test_full_vector();
      test_back_to_back_hold();
      test_flush();
      test_unknown();
      test_reset_midfill();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
